// File: rtl/perf_cnt_pkg.sv
// Shared types and helpers for the perf_counter_bank slice.
// The channel FSM state type and a width-agnostic saturating increment live here.
package perf_cnt_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    localparam int MAX_CH    = 16;
    localparam int SAT_MAX_W = 128;

    // Callers zero-extend into SAT_MAX_W bits and truncate the result back to w bits.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned          w);
        logic [SAT_MAX_W-1:0] top;
        top = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        return (v >= top) ? v : v + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/perf_cnt_channel.sv
// One go/done interval channel: IDLE/RUN FSM, live counter, last/runs/ovf results.
// Min/max interval tracking is built only when PERF_CNT_MINMAX_EN is defined.
//
//   state   | meaning
//   CH_IDLE | waiting for go; results held
//   CH_RUN  | interval in progress; live counts each non-done cycle
module perf_cnt_channel
    import perf_cnt_pkg::*;
#(
    parameter int CNT_W  = 64,
    parameter int RUNS_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              done,
    input  logic              clear,
    output logic              counting,
    output logic [CNT_W-1:0]  last,
    output logic [RUNS_W-1:0] runs,
    output logic              ovf
`ifdef PERF_CNT_MINMAX_EN
    ,
    output logic [CNT_W-1:0]  min_val,
    output logic [CNT_W-1:0]  max_val
`endif
);

    localparam logic [CNT_W-1:0] LIVE_MAX = '1;

    ch_state_t          state_q, state_d;
    logic [CNT_W-1:0]   live_q, live_d;
    logic [CNT_W-1:0]   last_d;
    logic [RUNS_W-1:0]  runs_d;
    logic               ovf_d;
`ifdef PERF_CNT_MINMAX_EN
    logic [CNT_W-1:0]   min_d, max_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CH_IDLE;
            live_q  <= '0;
            last    <= '0;
            runs    <= '0;
            ovf     <= 1'b0;
`ifdef PERF_CNT_MINMAX_EN
            min_val <= '1;
            max_val <= '0;
`endif
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            last    <= last_d;
            runs    <= runs_d;
            ovf     <= ovf_d;
`ifdef PERF_CNT_MINMAX_EN
            min_val <= min_d;
            max_val <= max_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        last_d  = last;
        runs_d  = runs;
        ovf_d   = ovf;
`ifdef PERF_CNT_MINMAX_EN
        min_d   = min_val;
        max_d   = max_val;
`endif
        if (clear) begin
            state_d = CH_IDLE;
            live_d  = '0;
            last_d  = '0;
            runs_d  = '0;
            ovf_d   = 1'b0;
`ifdef PERF_CNT_MINMAX_EN
            min_d   = '1;
            max_d   = '0;
`endif
        end else begin
            case (state_q)
                CH_IDLE: begin
                    if (go) begin
                        state_d = CH_RUN;
                        live_d  = '0;
                    end
                end
                CH_RUN: begin
                    // The done cycle itself is not counted; go while running is ignored.
                    if (done) begin
                        state_d = CH_IDLE;
                        last_d  = live_q;
                        runs_d  = RUNS_W'(sat_inc(SAT_MAX_W'(runs), RUNS_W));
`ifdef PERF_CNT_MINMAX_EN
                        if (live_q < min_val) min_d = live_q;
                        if (live_q > max_val) max_d = live_q;
`endif
                    end else begin
                        live_d = CNT_W'(sat_inc(SAT_MAX_W'(live_q), CNT_W));
                        if (live_q == LIVE_MAX) ovf_d = 1'b1;
                    end
                end
            endcase
        end
    end

    assign counting = (state_q == CH_RUN);

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel go/done interval counter bank with a 1-cycle registered read port.
// Define PERF_CNT_MINMAX_EN to build per-channel min/max tracking; otherwise rd_min_o/rd_max_o are 0.
module perf_counter_bank
    import perf_cnt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64,
    parameter int RUNS_W = 16,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] go_i,
    input  logic [NUM_CH-1:0] done_i,
    input  logic              clear_i,
    input  logic              rd_req_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  rd_count_o,
    output logic [RUNS_W-1:0] rd_runs_o,
    output logic              rd_ovf_o,
    output logic [CNT_W-1:0]  rd_min_o,
    output logic [CNT_W-1:0]  rd_max_o,
    output logic [NUM_CH-1:0] counting_o
);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("perf_counter_bank: NUM_CH out of range");
    end
    if (CNT_W > SAT_MAX_W || RUNS_W > SAT_MAX_W) begin : g_bad_width
        $error("perf_counter_bank: counter width exceeds sat_inc range");
    end

    logic [CNT_W-1:0]  ch_last [NUM_CH];
    logic [RUNS_W-1:0] ch_runs [NUM_CH];
    logic              ch_ovf  [NUM_CH];
`ifdef PERF_CNT_MINMAX_EN
    logic [CNT_W-1:0]  ch_min  [NUM_CH];
    logic [CNT_W-1:0]  ch_max  [NUM_CH];
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        perf_cnt_channel #(
            .CNT_W  (CNT_W),
            .RUNS_W (RUNS_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .go       (go_i[c]),
            .done     (done_i[c]),
            .clear    (clear_i),
            .counting (counting_o[c]),
            .last     (ch_last[c]),
            .runs     (ch_runs[c]),
            .ovf      (ch_ovf[c])
`ifdef PERF_CNT_MINMAX_EN
            ,
            .min_val  (ch_min[c]),
            .max_val  (ch_max[c])
`endif
        );
    end

    logic [CNT_W-1:0]  sel_count;
    logic [RUNS_W-1:0] sel_runs;
    logic              sel_ovf;
`ifdef PERF_CNT_MINMAX_EN
    logic [CNT_W-1:0]  sel_min, sel_max;
`endif

    // Out-of-range selects fall through to all-zero data.
    always_comb begin
        sel_count = '0;
        sel_runs  = '0;
        sel_ovf   = 1'b0;
`ifdef PERF_CNT_MINMAX_EN
        sel_min   = '0;
        sel_max   = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(rd_sel_i) == c) begin
                sel_count = ch_last[c];
                sel_runs  = ch_runs[c];
                sel_ovf   = ch_ovf[c];
`ifdef PERF_CNT_MINMAX_EN
                sel_min   = ch_min[c];
                sel_max   = ch_max[c];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_o <= 1'b0;
            rd_count_o <= '0;
            rd_runs_o  <= '0;
            rd_ovf_o   <= 1'b0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                rd_count_o <= sel_count;
                rd_runs_o  <= sel_runs;
                rd_ovf_o   <= sel_ovf;
            end
        end
    end

`ifdef PERF_CNT_MINMAX_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_min_o <= '1;
            rd_max_o <= '0;
        end else if (rd_req_i) begin
            rd_min_o <= sel_min;
            rd_max_o <= sel_max;
        end
    end
`else
    assign rd_min_o = '0;
    assign rd_max_o = '0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (NUM_CH=4, CNT_W=8, SEL_W=3) with a read scoreboard.
// Min/max expectations follow PERF_CNT_MINMAX_EN.
module tb_perf_counter_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int RUNS_W = 16;
    localparam int SEL_W  = 3;

`ifdef PERF_CNT_MINMAX_EN
    localparam bit          MM_EN   = 1'b1;
    localparam logic [7:0]  MIN_RST = 8'hFF;
`else
    localparam bit          MM_EN   = 1'b0;
    localparam logic [7:0]  MIN_RST = 8'h00;
`endif

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] go_i;
    logic [NUM_CH-1:0] done_i;
    logic              clear_i;
    logic              rd_req_i;
    logic [SEL_W-1:0]  rd_sel_i;
    logic              rd_valid_o;
    logic [CNT_W-1:0]  rd_count_o;
    logic [RUNS_W-1:0] rd_runs_o;
    logic              rd_ovf_o;
    logic [CNT_W-1:0]  rd_min_o;
    logic [CNT_W-1:0]  rd_max_o;
    logic [NUM_CH-1:0] counting_o;

    perf_counter_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .RUNS_W (RUNS_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go_i       (go_i),
        .done_i     (done_i),
        .clear_i    (clear_i),
        .rd_req_i   (rd_req_i),
        .rd_sel_i   (rd_sel_i),
        .rd_valid_o (rd_valid_o),
        .rd_count_o (rd_count_o),
        .rd_runs_o  (rd_runs_o),
        .rd_ovf_o   (rd_ovf_o),
        .rd_min_o   (rd_min_o),
        .rd_max_o   (rd_max_o),
        .counting_o (counting_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [7:0]  count;
        logic [15:0] runs;
        logic        ovf;
        logic        chk_mm;
        logic [7:0]  mn;
        logic [7:0]  mx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [7:0] mmv(input logic [7:0] v);
        return MM_EN ? v : 8'h00;
    endfunction

    // Scoreboard: every rd_valid_o pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rd_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rd_valid got=1 exp=0");
            end else begin
                mon_e = exp_q.pop_front();
                if (rd_count_o !== mon_e.count) begin
                    failures++;
                    $display("FAIL rd_count ch=%0d got=%0d exp=%0d", mon_e.sel, rd_count_o, mon_e.count);
                end
                checks++;
                if (rd_runs_o !== mon_e.runs) begin
                    failures++;
                    $display("FAIL rd_runs ch=%0d got=%0d exp=%0d", mon_e.sel, rd_runs_o, mon_e.runs);
                end
                checks++;
                if (rd_ovf_o !== mon_e.ovf) begin
                    failures++;
                    $display("FAIL rd_ovf ch=%0d got=%0d exp=%0d", mon_e.sel, rd_ovf_o, mon_e.ovf);
                end
                if (mon_e.chk_mm) begin
                    checks++;
                    if (rd_min_o !== mon_e.mn || rd_max_o !== mon_e.mx) begin
                        failures++;
                        $display("FAIL rd_minmax ch=%0d got=%0d/%0d exp=%0d/%0d",
                                 mon_e.sel, rd_min_o, rd_max_o, mon_e.mn, mon_e.mx);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    // go on one edge, done k edges later: last should read k-1.
    task automatic run_interval(input int ch, input int k);
        go_i[ch] = 1'b1;
        tick();
        go_i[ch] = 1'b0;
        repeat (k - 1) tick();
        done_i[ch] = 1'b1;
        tick();
        done_i[ch] = 1'b0;
    endtask

    task automatic issue_read(input logic [2:0] sel, input logic [7:0] cnt, input logic [15:0] rn,
                              input logic ov, input logic chk, input logic [7:0] mn, input logic [7:0] mx);
        exp_t e;
        e.sel = int'(sel); e.count = cnt; e.runs = rn; e.ovf = ov;
        e.chk_mm = chk; e.mn = mn; e.mx = mx;
        exp_q.push_back(e);
        rd_sel_i = sel;
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
    endtask

    task automatic wait_reads(input string name);
        for (int i = 0; i < 6 && exp_q.size() > 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_read_timeout pending=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rd_valid_o); end
        checks++;
        if (rd_count_o !== 8'd0 || rd_runs_o !== 16'd0 || rd_ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got=%0d/%0d/%0b exp=0/0/0", rd_count_o, rd_runs_o, rd_ovf_o);
        end
        checks++;
        if (counting_o !== 4'b0000) begin failures++; $display("FAIL reset_counting got=%b exp=0000", counting_o); end
        checks++;
        if (rd_min_o !== MIN_RST || rd_max_o !== 8'd0) begin
            failures++;
            $display("FAIL reset_minmax got=%0d/%0d exp=%0d/0", rd_min_o, rd_max_o, MIN_RST);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        repeat (9) tick();
        go_i[0] = 1'b1;
        tick();
        go_i[0] = 1'b0;
        repeat (4) tick();
        checks++;
        if (counting_o[0] !== 1'b1) begin failures++; $display("FAIL basic_counting_run got=%0b exp=1", counting_o[0]); end
        repeat (5) tick();
        done_i[0] = 1'b1;
        tick();
        done_i[0] = 1'b0;
        checks++;
        if (counting_o[0] !== 1'b0) begin failures++; $display("FAIL basic_counting_idle got=%0b exp=0", counting_o[0]); end
        issue_read(3'd0, 8'd9, 16'd1, 1'b0, 1'b1, mmv(8'd9), mmv(8'd9));
        wait_reads("basic");
        repeat (2) tick();
        checks++;
        if (rd_valid_o !== 1'b0 || rd_count_o !== 8'd9) begin
            failures++;
            $display("FAIL basic_hold got=%0b/%0d exp=0/9", rd_valid_o, rd_count_o);
        end
    endtask

    task automatic test_concurrent();
        pulse_clear();
        for (int t = 0; t <= 100; t++) begin
            go_i   = '0;
            done_i = '0;
            if (t == 0 || t == 50) go_i[2] = 1'b1;
            if (t == 100) done_i[2] = 1'b1;
            if (t == 10 || t == 20 || t == 30) go_i[1] = 1'b1;
            if (t == 15 || t == 25 || t == 35) done_i[1] = 1'b1;
            tick();
            if (t == 60) begin
                checks++;
                if (counting_o !== 4'b0100) begin
                    failures++;
                    $display("FAIL concurrent_counting got=%b exp=0100", counting_o);
                end
            end
        end
        go_i   = '0;
        done_i = '0;
        issue_read(3'd1, 8'd4, 16'd3, 1'b0, 1'b1, mmv(8'd4), mmv(8'd4));
        issue_read(3'd2, 8'd99, 16'd1, 1'b0, 1'b1, mmv(8'd99), mmv(8'd99));
        wait_reads("concurrent");
    endtask

    task automatic test_overflow();
        pulse_clear();
        run_interval(0, 300);
        issue_read(3'd0, 8'd255, 16'd1, 1'b1, 1'b1, mmv(8'd255), mmv(8'd255));
        run_interval(0, 10);
        issue_read(3'd0, 8'd9, 16'd2, 1'b1, 1'b1, mmv(8'd9), mmv(8'd255));
        wait_reads("overflow");
        pulse_clear();
        issue_read(3'd0, 8'd0, 16'd0, 1'b0, 1'b1, MIN_RST, 8'd0);
        wait_reads("overflow_clear");
    endtask

    task automatic test_priority();
        pulse_clear();
        go_i[3]   = 1'b1;
        done_i[3] = 1'b1;
        tick();
        go_i[3]   = 1'b0;
        done_i[3] = 1'b0;
        checks++;
        if (counting_o[3] !== 1'b1) begin failures++; $display("FAIL prio_go_done got=%0b exp=1", counting_o[3]); end
        repeat (2) tick();
        done_i[3] = 1'b1;
        tick();
        done_i[3] = 1'b0;
        issue_read(3'd3, 8'd2, 16'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        wait_reads("prio_go_done");

        clear_i = 1'b1;
        go_i[1] = 1'b1;
        tick();
        clear_i = 1'b0;
        go_i[1] = 1'b0;
        checks++;
        if (counting_o[1] !== 1'b0) begin failures++; $display("FAIL prio_clear_go got=%0b exp=0", counting_o[1]); end
        issue_read(3'd3, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        wait_reads("prio_clear");

        run_interval(0, 4);
        go_i[0] = 1'b1;
        tick();
        go_i[0] = 1'b0;
        repeat (5) tick();
        done_i[0] = 1'b1;
        issue_read(3'd0, 8'd3, 16'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        done_i[0] = 1'b0;
        issue_read(3'd0, 8'd5, 16'd2, 1'b0, 1'b0, 8'd0, 8'd0);
        wait_reads("prio_done_read");

        issue_read(3'd4, 8'd0, 16'd0, 1'b0, 1'b1, 8'd0, 8'd0);
        wait_reads("prio_oob");
    endtask

    task automatic test_reset_mid();
        pulse_clear();
        run_interval(1, 6);
        issue_read(3'd1, 8'd5, 16'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        wait_reads("rstmid_pre");
        go_i[0] = 1'b1;
        go_i[3] = 1'b1;
        tick();
        go_i = '0;
        repeat (3) tick();
        checks++;
        if (counting_o !== 4'b1001) begin failures++; $display("FAIL rstmid_running got=%b exp=1001", counting_o); end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (counting_o !== 4'b0000 || rd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_ctrl got=%b/%0b exp=0000/0", counting_o, rd_valid_o);
        end
        checks++;
        if (rd_count_o !== 8'd0 || rd_runs_o !== 16'd0 || rd_ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_data got=%0d/%0d/%0b exp=0/0/0", rd_count_o, rd_runs_o, rd_ovf_o);
        end
        checks++;
        if (rd_min_o !== MIN_RST || rd_max_o !== 8'd0) begin
            failures++;
            $display("FAIL rstmid_minmax got=%0d/%0d exp=%0d/0", rd_min_o, rd_max_o, MIN_RST);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        run_interval(0, 7);
        issue_read(3'd0, 8'd6, 16'd1, 1'b0, 1'b1, mmv(8'd6), mmv(8'd6));
        issue_read(3'd1, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        wait_reads("rstmid_post");
    endtask

    task automatic test_minmax();
        pulse_clear();
        run_interval(0, 12);
        run_interval(0, 3);
        run_interval(0, 8);
        issue_read(3'd0, 8'd7, 16'd3, 1'b0, 1'b1, mmv(8'd2), mmv(8'd11));
        wait_reads("minmax");
    endtask

    initial begin
        reset    = 1'b1;
        go_i     = '0;
        done_i   = '0;
        clear_i  = 1'b0;
        rd_req_i = 1'b0;
        rd_sel_i = '0;
        test_reset();
        test_basic();
        test_concurrent();
        test_overflow();
        test_priority();
        test_reset_mid();
        test_minmax();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
